// File: rtl/battle_engine.sv
// rtl/battle_engine.sv - turn-based battle FSM with cursor menu, HP bookkeeping and health bars
module battle_engine #(
  parameter int HP_W        = 8,
  parameter int ENEMY_HP    = 100,
  parameter int PLAYER_DMG  = 20,
  parameter int ENEMY_DMG   = 10,
  parameter int HEAL_AMT    = 25,
  parameter int ENEMY_DELAY = 20,
  parameter int END_DELAY   = 10,
  parameter int BAR_SHIFT   = 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            start,
  input  logic            frame_tick,
  input  logic            left_in,
  input  logic            right_in,
  input  logic            up_in,
  input  logic            down_in,
  input  logic            select,
  input  logic [HP_W-1:0] health_in,
  input  logic [7:0]      rand_in,
  output logic [HP_W-1:0] health_out,
  output logic [HP_W-1:0] enemy_health,
  output logic [HP_W-1:0] player_bar,
  output logic [HP_W-1:0] enemy_bar,
  output logic            cursor_x,
  output logic            cursor_y,
  output logic [3:0]      enemy_sel_x,
  output logic            enemy_sel_y,
  output logic [1:0]      outcome,
  output logic            run,
  output logic [2:0]      state_out
);

  localparam int W2    = HP_W + 2;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_INIT = 3'd1, S_MENU = 3'd2, S_PLAYER_ACT = 3'd3,
    S_ENEMY_WAIT = 3'd4, S_END_WAIT = 3'd5, S_DONE = 3'd6
  } state_t;

  // Move code is {cursor_y, cursor_x} captured at select time
  localparam logic [1:0] MV_FIGHT   = 2'd0;
  localparam logic [1:0] MV_SPECIAL = 2'd1;
  localparam logic [1:0] MV_HEAL    = 2'd2;
  localparam logic [1:0] MV_RUN     = 2'd3;

  state_t           state_q, state_d;
  logic [HP_W-1:0]  health_q, health_d, max_q, max_d, enemy_q, enemy_d;
  logic [HP_W-1:0]  pbar_q, pbar_d, ebar_q, ebar_d;
  logic             cx_q, cx_d, cy_q, cy_d, sel_y_q, sel_y_d, run_q, run_d;
  logic [3:0]       sel_x_q, sel_x_d;
  logic [1:0]       outcome_q, outcome_d, move_q, move_d;
  logic [CNT_W-1:0] counter_q, counter_d;

  // Widened arithmetic so sums never wrap before saturation
  logic [W2-1:0] hp_ext, en_ext, max_ext, heal_sum, player_dmg, enemy_hit;
  logic [HP_W-1:0] enemy_after, heal_after, hit_after;

  // Damage, heal and saturation results for the current cycle
  always_comb begin
    hp_ext     = {2'b00, health_q};
    en_ext     = {2'b00, enemy_q};
    max_ext    = {2'b00, max_q};
    heal_sum   = hp_ext + W2'(HEAL_AMT);
    enemy_hit  = W2'(ENEMY_DMG) + W2'(rand_in[1:0]);
    player_dmg = '0;
    if (move_q == MV_FIGHT) player_dmg = W2'(PLAYER_DMG) + W2'(rand_in[1:0]);
    else if (move_q == MV_SPECIAL && rand_in[7]) player_dmg = W2'(2 * PLAYER_DMG);
    enemy_after = (en_ext > player_dmg) ? HP_W'(en_ext - player_dmg) : '0;
    heal_after  = (heal_sum > max_ext) ? max_q : HP_W'(heal_sum);
    hit_after   = (hp_ext > enemy_hit) ? HP_W'(hp_ext - enemy_hit) : '0;
  end

  // Next-state and next-value logic for the battle FSM
  always_comb begin
    state_d   = state_q;
    health_d  = health_q;
    max_d     = max_q;
    enemy_d   = enemy_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    sel_x_d   = sel_x_q;
    sel_y_d   = sel_y_q;
    outcome_d = outcome_q;
    move_d    = move_q;
    counter_d = counter_q;
    pbar_d    = health_q >> BAR_SHIFT;
    ebar_d    = enemy_q >> BAR_SHIFT;

    if (!start && state_q != S_IDLE && state_q != S_DONE) begin
      // Abort mid-battle: HP values are intentionally kept
      state_d   = S_IDLE;
      outcome_d = 2'd0;
      counter_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = S_INIT;
        S_INIT: begin
          enemy_d   = HP_W'(ENEMY_HP);
          health_d  = health_in;
          max_d     = health_in;
          sel_x_d   = (rand_in[3:0] == 4'hF) ? 4'hE : rand_in[3:0];
          sel_y_d   = rand_in[4];
          cx_d      = 1'b0;
          cy_d      = 1'b0;
          counter_d = '0;
          if (health_in == '0) begin
            outcome_d = 2'd2;
            state_d   = S_END_WAIT;
          end else begin
            outcome_d = 2'd0;
            state_d   = S_MENU;
          end
        end
        S_MENU: if (frame_tick) begin
          if (left_in) cx_d = 1'b0;
          else if (right_in) cx_d = 1'b1;
          if (up_in) cy_d = 1'b0;
          else if (down_in) cy_d = 1'b1;
          if (select) begin
            move_d = {cy_q, cx_q};
            if ({cy_q, cx_q} == MV_RUN) begin
              outcome_d = 2'd3;
              state_d   = S_DONE;
            end else begin
              state_d = S_PLAYER_ACT;
            end
          end
        end
        S_PLAYER_ACT: if (frame_tick) begin
          counter_d = '0;
          if (move_q == MV_HEAL) health_d = heal_after;
          else enemy_d = enemy_after;
          if (move_q != MV_HEAL && enemy_after == '0) begin
            outcome_d = 2'd1;
            state_d   = S_END_WAIT;
          end else begin
            state_d = S_ENEMY_WAIT;
          end
        end
        S_ENEMY_WAIT: if (frame_tick) begin
          if (counter_q == CNT_W'(ENEMY_DELAY - 1)) begin
            health_d  = hit_after;
            counter_d = '0;
            if (hit_after == '0) begin
              outcome_d = 2'd2;
              state_d   = S_END_WAIT;
            end else begin
              state_d = S_MENU;
            end
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
        S_END_WAIT: if (frame_tick) begin
          if (counter_q == CNT_W'(END_DELAY - 1)) begin
            counter_d = '0;
            state_d   = S_DONE;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
        S_DONE: if (!start) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    run_d = (state_d == S_DONE);
  end

  // All state registers, with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      health_q  <= health_in;
      max_q     <= health_in;
      enemy_q   <= HP_W'(ENEMY_HP);
      cx_q      <= 1'b0;
      cy_q      <= 1'b0;
      sel_x_q   <= 4'd0;
      sel_y_q   <= 1'b0;
      outcome_q <= 2'd0;
      move_q    <= MV_FIGHT;
      counter_q <= '0;
      run_q     <= 1'b0;
      pbar_q    <= health_in >> BAR_SHIFT;
      ebar_q    <= HP_W'(ENEMY_HP) >> BAR_SHIFT;
    end else begin
      state_q   <= state_d;
      health_q  <= health_d;
      max_q     <= max_d;
      enemy_q   <= enemy_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      sel_x_q   <= sel_x_d;
      sel_y_q   <= sel_y_d;
      outcome_q <= outcome_d;
      move_q    <= move_d;
      counter_q <= counter_d;
      run_q     <= run_d;
      pbar_q    <= pbar_d;
      ebar_q    <= ebar_d;
    end
  end

  assign health_out   = health_q;
  assign enemy_health = enemy_q;
  assign player_bar   = pbar_q;
  assign enemy_bar    = ebar_q;
  assign cursor_x     = cx_q;
  assign cursor_y     = cy_q;
  assign enemy_sel_x  = sel_x_q;
  assign enemy_sel_y  = sel_y_q;
  assign outcome      = outcome_q;
  assign run          = run_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_battle_engine.sv
// tb/tb_battle_engine.sv - directed self-checking bench for battle_engine
module tb_battle_engine;

  logic       clk_in = 1'b0;
  logic       rst_in, start, frame_tick, left_in, right_in, up_in, down_in, select;
  logic [7:0] health_in, rand_in;
  logic [7:0] health_out, enemy_health, player_bar, enemy_bar;
  logic       cursor_x, cursor_y, enemy_sel_y, run;
  logic [3:0] enemy_sel_x;
  logic [1:0] outcome;
  logic [2:0] state_out;

  int total = 0;
  int bad   = 0;

  battle_engine dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .frame_tick(frame_tick),
    .left_in(left_in), .right_in(right_in), .up_in(up_in), .down_in(down_in),
    .select(select), .health_in(health_in), .rand_in(rand_in),
    .health_out(health_out), .enemy_health(enemy_health),
    .player_bar(player_bar), .enemy_bar(enemy_bar),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .enemy_sel_x(enemy_sel_x), .enemy_sel_y(enemy_sel_y),
    .outcome(outcome), .run(run), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic tick, l, r, u, d;
    logic ex, ey;
  } cur_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges and settle 1ns past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic begin_battle(input logic [7:0] h, input logic [7:0] r);
    health_in = h;
    rand_in   = r;
    start     = 1'b1;
    cyc(1);
    check("idle_to_init", state_out, 1);
    cyc(1);
  endtask

  task automatic end_battle();
    start = 1'b0;
    cyc(1);
  endtask

  task automatic pick(input logic l, input logic r, input logic u, input logic d);
    left_in = l; right_in = r; up_in = u; down_in = d;
    frame();
    left_in = 0; right_in = 0; up_in = 0; down_in = 0;
  endtask

  task automatic choose();
    select = 1'b1;
    frame();
    select = 1'b0;
  endtask

  cur_vec_t cur_tab[7];

  initial begin
    cur_tab[0] = '{1, 0, 1, 0, 0, 1, 0};
    cur_tab[1] = '{1, 0, 0, 0, 1, 1, 1};
    cur_tab[2] = '{1, 1, 1, 0, 0, 0, 1};
    cur_tab[3] = '{1, 0, 0, 1, 1, 0, 0};
    cur_tab[4] = '{1, 1, 0, 0, 1, 0, 1};
    cur_tab[5] = '{1, 0, 0, 0, 0, 0, 1};
    cur_tab[6] = '{0, 0, 1, 1, 0, 0, 1};

    rst_in = 1; start = 0; frame_tick = 0; select = 0;
    left_in = 0; right_in = 0; up_in = 0; down_in = 0;
    health_in = 8'd50; rand_in = 8'd0;
    cyc(2);
    rst_in = 0;
    check("rst_state", state_out, 0);
    check("rst_health", health_out, 50);
    check("rst_enemy", enemy_health, 100);
    check("rst_pbar", player_bar, 25);
    check("rst_ebar", enemy_bar, 50);
    check("rst_run", run, 0);
    check("rst_outcome", outcome, 0);

    // Cursor moves from the table, all in MENU without select
    begin_battle(8'd50, 8'd0);
    check("menu_entry", state_out, 2);
    for (int i = 0; i < 7; i++) begin
      left_in = cur_tab[i].l; right_in = cur_tab[i].r;
      up_in = cur_tab[i].u; down_in = cur_tab[i].d;
      frame_tick = cur_tab[i].tick;
      cyc(1);
      frame_tick = 0; left_in = 0; right_in = 0; up_in = 0; down_in = 0;
      check($sformatf("cur_x_%0d", i), cursor_x, cur_tab[i].ex);
      check($sformatf("cur_y_%0d", i), cursor_y, cur_tab[i].ey);
      check($sformatf("cur_state_%0d", i), state_out, 2);
    end
    end_battle();
    check("abort_from_menu", state_out, 0);

    // Win: five FIGHTs, four enemy hits
    begin_battle(8'd50, 8'd0);
    for (int i = 0; i < 5; i++) begin
      choose();
      check($sformatf("win_act_%0d", i), state_out, 3);
      frame();
      check($sformatf("win_enemy_%0d", i), enemy_health, 80 - 20 * i);
      if (i < 4) begin
        check($sformatf("win_wait_%0d", i), state_out, 4);
        repeat (20) frame();
        check($sformatf("win_hp_%0d", i), health_out, 40 - 10 * i);
        check($sformatf("win_menu_%0d", i), state_out, 2);
      end
    end
    check("win_endwait", state_out, 5);
    check("win_outcome_early", outcome, 1);
    repeat (9) frame();
    check("win_still_endwait", state_out, 5);
    check("win_run_early", run, 0);
    frame();
    check("win_done", state_out, 6);
    check("win_outcome", outcome, 1);
    check("win_run", run, 1);
    check("win_health", health_out, 10);
    check("win_pbar", player_bar, 5);
    check("win_ebar", enemy_bar, 0);
    end_battle();
    check("done_to_idle", state_out, 0);
    check("done_outcome_kept", outcome, 1);

    // Loss: rand=3 gives 23 player damage, 13 enemy damage
    begin_battle(8'd15, 8'h03);
    choose();
    frame();
    check("loss_enemy1", enemy_health, 77);
    repeat (19) frame();
    check("loss_wait_edge", state_out, 4);
    check("loss_hp_before", health_out, 15);
    frame();
    check("loss_hp1", health_out, 2);
    check("loss_bar_lag", player_bar, 7);
    cyc(1);
    check("loss_bar_upd", player_bar, 1);
    choose();
    frame();
    check("loss_enemy2", enemy_health, 54);
    repeat (20) frame();
    check("loss_hp2", health_out, 0);
    check("loss_state", state_out, 5);
    check("loss_outcome", outcome, 2);
    end_battle();

    // Heal is capped at the starting HP
    begin_battle(8'd40, 8'd0);
    choose();
    frame();
    repeat (20) frame();
    check("heal_hit", health_out, 30);
    pick(0, 0, 0, 1);
    check("heal_cursor", cursor_y, 1);
    choose();
    check("heal_act", state_out, 3);
    frame();
    check("heal_cap", health_out, 40);
    check("heal_enemy_same", enemy_health, 80);
    end_battle();

    // Flee via RUN
    begin_battle(8'd50, 8'd0);
    pick(0, 1, 0, 0);
    pick(0, 0, 0, 1);
    choose();
    check("flee_state", state_out, 6);
    check("flee_outcome", outcome, 3);
    check("flee_run", run, 1);
    check("flee_enemy", enemy_health, 100);
    end_battle();
    check("flee_run_off", run, 0);

    // Abort in ENEMY_WAIT with counter at 7, then restart
    begin_battle(8'd50, 8'd0);
    choose();
    frame();
    repeat (7) frame();
    check("abort_wait", state_out, 4);
    start = 0;
    cyc(1);
    check("abort_state", state_out, 0);
    check("abort_outcome", outcome, 0);
    check("abort_enemy_kept", enemy_health, 80);
    begin_battle(8'd50, 8'd0);
    check("restart_menu", state_out, 2);
    check("restart_enemy", enemy_health, 100);
    end_battle();

    // Sprite selection saturation
    begin_battle(8'd50, 8'h1F);
    check("sel_x_sat", enemy_sel_x, 14);
    check("sel_y_sat", enemy_sel_y, 1);
    end_battle();
    begin_battle(8'd50, 8'h05);
    check("sel_x_plain", enemy_sel_x, 5);
    check("sel_y_plain", enemy_sel_y, 0);
    end_battle();

    // Zero starting HP loses immediately
    begin_battle(8'd0, 8'd0);
    check("zero_endwait", state_out, 5);
    check("zero_outcome", outcome, 2);
    repeat (10) frame();
    check("zero_done", state_out, 6);
    end_battle();

    // Reset during PLAYER_ACT
    begin_battle(8'd50, 8'h13);
    choose();
    frame();
    repeat (20) frame();
    check("mid_hp", health_out, 37);
    pick(0, 0, 0, 1);
    choose();
    check("mid_act", state_out, 3);
    rst_in = 1;
    cyc(1);
    rst_in = 0;
    check("mid_rst_state", state_out, 0);
    check("mid_rst_health", health_out, 50);
    check("mid_rst_enemy", enemy_health, 100);
    check("mid_rst_cx", cursor_x, 0);
    check("mid_rst_cy", cursor_y, 0);
    check("mid_rst_selx", enemy_sel_x, 0);
    check("mid_rst_sely", enemy_sel_y, 0);
    check("mid_rst_outcome", outcome, 0);
    check("mid_rst_run", run, 0);
    check("mid_rst_pbar", player_bar, 25);
    check("mid_rst_ebar", enemy_bar, 50);
    frame();
    check("mid_rst_hold", state_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
